// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared core defines for the EX-stage divide sequencer.
// Widths, reset level and FSM state encodings.
package div_seq_pkg;

  localparam int RegWidth       = 32;
  localparam int DoubleRegWidth = 2 * RegWidth;
  localparam logic RstEnable    = 1'b1;

  typedef enum logic [1:0] {
    DSeqIdle  = 2'b00,
    DSeqRun   = 2'b01,
    DSeqRecov = 2'b10,
    DSeqDrain = 2'b11
  } dseq_state_e;

endpackage

// File: rtl/div_seq.sv
// div_seq: launches the iterative divider from EX, stalls until done,
// presents {rem, quot} as HI/LO for one cycle, and cancels on flush.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int REG_W   = RegWidth,
  parameter int TIMEOUT = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_div_req,
  input  logic               ex_signed,
  input  logic [REG_W-1:0]   ex_op1,
  input  logic [REG_W-1:0]   ex_op2,
  input  logic               ex_flush,
  output logic               stall_req,
  output logic               div_start,
  output logic               div_cancel,
  output logic               div_signed,
  output logic [REG_W-1:0]   div_opdata1,
  output logic [REG_W-1:0]   div_opdata2,
  input  logic [2*REG_W-1:0] div_res,
  input  logic               div_done,
  output logic               hilo_valid,
  output logic [REG_W-1:0]   hi_o,
  output logic [REG_W-1:0]   lo_o,
  output logic               err_timeout
);

  localparam int CntW = 6;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  dseq_state_e     state;
  logic [CntW-1:0] cnt;
  logic            launch;
  logic            abort;

  assign launch = ex_div_req && !ex_flush;
  // done wins over a timeout landing in the same cycle
  assign abort  = ex_flush || (!div_done && cnt == CntLast);

  always_comb begin
    stall_req  = 1'b0;
    hilo_valid = 1'b0;
    if (rst != RstEnable) begin
      unique case (state)
        DSeqIdle: stall_req = launch;
        DSeqRun: begin
          stall_req  = !div_done;
          hilo_valid = div_done && !ex_flush;
        end
        DSeqRecov: stall_req = ex_div_req;
        DSeqDrain: stall_req = ex_div_req;
        default:   stall_req = 1'b0;
      endcase
    end
  end

  assign hi_o = hilo_valid ? div_res[2*REG_W-1:REG_W] : '0;
  assign lo_o = hilo_valid ? div_res[REG_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state       <= DSeqIdle;
      cnt         <= '0;
      div_start   <= 1'b0;
      div_cancel  <= 1'b0;
      div_signed  <= 1'b0;
      div_opdata1 <= '0;
      div_opdata2 <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      unique case (state)
        DSeqIdle: begin
          if (launch) begin
            div_opdata1 <= ex_op1;
            div_opdata2 <= ex_op2;
            div_signed  <= ex_signed;
            div_start   <= 1'b1;
            cnt         <= '0;
            state       <= DSeqRun;
          end
        end
        DSeqRun: begin
          if (abort) begin
            div_start   <= 1'b0;
            div_cancel  <= 1'b1;
            err_timeout <= !ex_flush;
            cnt         <= '0;
            state       <= DSeqDrain;
          end else if (div_done) begin
            div_start <= 1'b0;
            state     <= DSeqRecov;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        DSeqRecov: state <= DSeqIdle;
        DSeqDrain: begin
          if (cnt == CntOne) begin
            div_cancel <= 1'b0;
            state      <= DSeqIdle;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        default: state <= DSeqIdle;
      endcase
    end
  end

endmodule
